// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register for the Y86-64 pipelined processor. The same module
// is used at every inter-stage boundary (F/D, D/E, E/M, M/W).
//
// Each rising edge of clk does exactly one of the following, highest priority
// first:
//   reset (rst_n=0) : load the NOP payload and clear every flag and counter
//   frozen          : hold the payload; the counters stay where they are
//   stall           : hold the payload and count a stall cycle. A bubble in
//                     the same cycle is ignored and sets the conflict flag.
//   bubble          : load the NOP payload and count a bubble cycle
//   otherwise       : load the in_* fields
//
// The pipeline control signals (stall, bubble) are plain level inputs that are
// sampled at every edge. There is no valid/ready handshake on this register.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   stall, bubble       pipeline control inputs
//   in_stat/in_icode    upstream status and instruction code   (CODE_W)
//   in_valE/in_valM     upstream data values                   (DATA_W)
//   in_dstE/in_dstM     upstream destination register IDs      (REG_W)
//   out_*               registered copies of the in_* fields
//   frozen              sticky: an exception stat was captured, register held
//   conflict            sticky: stall and bubble were asserted in one cycle
//   stall_cnt           saturating count of stall cycles        (CNT_W)
//   bubble_cnt          saturating count of bubble cycles       (CNT_W)
//
// Every output is driven directly from a flop. There is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W        = 64,
  parameter int                REG_W         = 4,
  parameter int                CODE_W        = 4,
  parameter int                CNT_W         = 16,
  parameter logic [CODE_W-1:0] BUBBLE_ICODE  = 4'h1,
  parameter logic [CODE_W-1:0] BUBBLE_STAT   = 4'h1,
  parameter logic [REG_W-1:0]  RNONE         = 4'hF,
  parameter bit                FREEZE_ON_EXC = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              bubble,
  input  logic [CODE_W-1:0] in_stat,
  input  logic [CODE_W-1:0] in_icode,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [DATA_W-1:0] in_valM,
  input  logic [REG_W-1:0]  in_dstE,
  input  logic [REG_W-1:0]  in_dstM,
  output logic [CODE_W-1:0] out_stat,
  output logic [CODE_W-1:0] out_icode,
  output logic [DATA_W-1:0] out_valE,
  output logic [DATA_W-1:0] out_valM,
  output logic [REG_W-1:0]  out_dstE,
  output logic [REG_W-1:0]  out_dstM,
  output logic              frozen,
  output logic              conflict,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CODE_W-1:0] stat_q,  stat_d;
  logic [CODE_W-1:0] icode_q, icode_d;
  logic [DATA_W-1:0] vale_q,  vale_d;
  logic [DATA_W-1:0] valm_q,  valm_d;
  logic [REG_W-1:0]  dste_q,  dste_d;
  logic [REG_W-1:0]  dstm_q,  dstm_d;
  logic              frozen_q,   frozen_d;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  // Next-state logic. The default is to hold everything, which covers the
  // frozen case on its own.
  always_comb begin
    stat_d       = stat_q;
    icode_d      = icode_q;
    vale_d       = vale_q;
    valm_d       = valm_q;
    dste_d       = dste_q;
    dstm_d       = dstm_q;
    frozen_d     = frozen_q;
    conflict_d   = conflict_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (!frozen_q) begin
      if (stall) begin
        // The stall wins. A bubble in the same cycle is dropped, not counted,
        // and recorded as a control conflict.
        stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
        if (bubble) begin
          conflict_d = 1'b1;
        end
      end else if (bubble) begin
        stat_d       = BUBBLE_STAT;
        icode_d      = BUBBLE_ICODE;
        vale_d       = '0;
        valm_d       = '0;
        dste_d       = RNONE;
        dstm_d       = RNONE;
        bubble_cnt_d = (bubble_cnt_q == CNT_MAX) ? bubble_cnt_q : bubble_cnt_q + CNT_ONE;
      end else begin
        stat_d  = in_stat;
        icode_d = in_icode;
        vale_d  = in_valE;
        valm_d  = in_valM;
        dste_d  = in_dstE;
        dstm_d  = in_dstM;
        // Only a normal load can capture an exception. A bubble always
        // carries SAOK, so it can never set frozen.
        if (FREEZE_ON_EXC && (in_stat != BUBBLE_STAT)) begin
          frozen_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q       <= BUBBLE_STAT;
      icode_q      <= BUBBLE_ICODE;
      vale_q       <= '0;
      valm_q       <= '0;
      dste_q       <= RNONE;
      dstm_q       <= RNONE;
      frozen_q     <= 1'b0;
      conflict_q   <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stat_q       <= stat_d;
      icode_q      <= icode_d;
      vale_q       <= vale_d;
      valm_q       <= valm_d;
      dste_q       <= dste_d;
      dstm_q       <= dstm_d;
      frozen_q     <= frozen_d;
      conflict_q   <= conflict_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_stat   = stat_q;
  assign out_icode  = icode_q;
  assign out_valE   = vale_q;
  assign out_valM   = valm_q;
  assign out_dstE   = dste_q;
  assign out_dstM   = dstm_q;
  assign frozen     = frozen_q;
  assign conflict   = conflict_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. It uses two instances:
//   u_dut : default parameters
//   u_sat : CNT_W=3, so that counter saturation can be reached quickly
// Both instances see the same stimulus.
//
// How the bench works:
//   - The driver changes the inputs on the falling edge. At the same time it
//     pushes the hand-computed state that both instances must show after the
//     next rising edge.
//   - The monitor samples the outputs #1 after each rising edge. Whenever an
//     expectation is queued, it pops one and compares every field.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] vale;
    logic [63:0] valm;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic        frz;
    logic        cfl;
    logic [15:0] sc;
    logic [15:0] bc;
    logic [2:0]  ssc;
    logic [2:0]  sbc;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  = 1'b0;
  logic        stall  = 1'b0;
  logic        bubble = 1'b0;
  logic [3:0]  in_stat  = 4'h1;
  logic [3:0]  in_icode = 4'h0;
  logic [63:0] in_valE  = '0;
  logic [63:0] in_valM  = '0;
  logic [3:0]  in_dstE  = 4'h0;
  logic [3:0]  in_dstM  = 4'h0;

  logic [3:0]  out_stat, out_icode, out_dstE, out_dstM;
  logic [63:0] out_valE, out_valM;
  logic        frozen, conflict;
  logic [15:0] stall_cnt, bubble_cnt;

  logic [3:0]  s_stat, s_icode, s_dstE, s_dstM;
  logic [63:0] s_valE, s_valM;
  logic        s_frozen, s_conflict;
  logic [2:0]  s_stall_cnt, s_bubble_cnt;

  pipe_stage_reg u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_valE(in_valE), .in_valM(in_valM),
    .in_dstE(in_dstE), .in_dstM(in_dstM),
    .out_stat(out_stat), .out_icode(out_icode), .out_valE(out_valE), .out_valM(out_valM),
    .out_dstE(out_dstE), .out_dstM(out_dstM),
    .frozen(frozen), .conflict(conflict), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_valE(in_valE), .in_valM(in_valM),
    .in_dstE(in_dstE), .in_dstM(in_dstM),
    .out_stat(s_stat), .out_icode(s_icode), .out_valE(s_valE), .out_valM(s_valM),
    .out_dstE(s_dstE), .out_dstM(s_dstM),
    .frozen(s_frozen), .conflict(s_conflict), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [3:0] i_stat, input logic [3:0] i_icode,
                      input logic [63:0] i_vale, input logic [63:0] i_valm,
                      input logic [3:0] i_dste, input logic [3:0] i_dstm,
                      input logic [3:0] x_stat, input logic [3:0] x_icode,
                      input logic [63:0] x_vale, input logic [63:0] x_valm,
                      input logic [3:0] x_dste, input logic [3:0] x_dstm,
                      input logic x_frz, input logic x_cfl,
                      input int x_sc, input int x_bc, input int x_ssc);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    stall    = s;
    bubble   = b;
    in_stat  = i_stat;
    in_icode = i_icode;
    in_valE  = i_vale;
    in_valM  = i_valm;
    in_dstE  = i_dste;
    in_dstM  = i_dstm;
    e.stat  = x_stat;
    e.icode = x_icode;
    e.vale  = x_vale;
    e.valm  = x_valm;
    e.dste  = x_dste;
    e.dstm  = x_dstm;
    e.frz   = x_frz;
    e.cfl   = x_cfl;
    e.sc    = 16'(x_sc);
    e.bc    = 16'(x_bc);
    e.ssc   = 3'(x_ssc);
    e.sbc   = 3'(x_bc);
    exp_q.push_back(EXP_W'(e));
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_t'(exp_q.pop_front());
      chk("out_stat",     64'(out_stat),     64'(e.stat));
      chk("out_icode",    64'(out_icode),    64'(e.icode));
      chk("out_valE",     out_valE,          e.vale);
      chk("out_valM",     out_valM,          e.valm);
      chk("out_dstE",     64'(out_dstE),     64'(e.dste));
      chk("out_dstM",     64'(out_dstM),     64'(e.dstm));
      chk("frozen",       64'(frozen),       64'(e.frz));
      chk("conflict",     64'(conflict),     64'(e.cfl));
      chk("stall_cnt",    64'(stall_cnt),    64'(e.sc));
      chk("bubble_cnt",   64'(bubble_cnt),   64'(e.bc));
      chk("sat_icode",    64'(s_icode),      64'(e.icode));
      chk("sat_valE",     s_valE,            e.vale);
      chk("sat_frozen",   64'(s_frozen),     64'(e.frz));
      chk("sat_stall",    64'(s_stall_cnt),  64'(e.ssc));
      chk("sat_bubble",   64'(s_bubble_cnt), 64'(e.sbc));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Hold reset for two edges, with junk on the inputs.
    step(0,1,1, 4'h3,4'h9,64'hDEAD,64'hBEEF,4'h2,4'h2,  4'h1,4'h1,64'h0,64'h0,4'hF,4'hF, 0,0, 0,0,0);
    step(0,0,0, 4'h3,4'h9,64'hDEAD,64'hBEEF,4'h2,4'h2,  4'h1,4'h1,64'h0,64'h0,4'hF,4'hF, 0,0, 0,0,0);
    // Pass-through with a one-cycle delay.
    step(1,0,0, 4'h1,4'h6,64'h1234,64'h55,4'h3,4'h5,    4'h1,4'h6,64'h1234,64'h55,4'h3,4'h5, 0,0, 0,0,0);
    step(1,0,0, 4'h1,4'h6,64'hAA,64'h66,4'h3,4'h5,      4'h1,4'h6,64'hAA,64'h66,4'h3,4'h5, 0,0, 0,0,0);
    // Stall for three edges: the payload holds while the counter climbs.
    for (int i = 1; i <= 3; i++)
      step(1,1,0, 4'h1,4'h6,64'hBB,64'h77,4'h3,4'h5,    4'h1,4'h6,64'hAA,64'h66,4'h3,4'h5, 0,0, i,0,i);
    step(1,0,0, 4'h1,4'h6,64'hBB,64'h77,4'h3,4'h5,      4'h1,4'h6,64'hBB,64'h77,4'h3,4'h5, 0,0, 3,0,3);
    // Bubble: load the NOP payload.
    step(1,0,1, 4'h1,4'h6,64'hBB,64'h77,4'h3,4'h5,      4'h1,4'h1,64'h0,64'h0,4'hF,4'hF, 0,0, 3,1,3);
    step(1,0,0, 4'h1,4'h6,64'hCC,64'h10,4'h2,4'h4,      4'h1,4'h6,64'hCC,64'h10,4'h2,4'h4, 0,0, 3,1,3);
    // Stall and bubble together: the stall wins and conflict becomes set.
    step(1,1,1, 4'h1,4'h7,64'hDD,64'h20,4'h1,4'h2,      4'h1,4'h6,64'hCC,64'h10,4'h2,4'h4, 0,1, 4,1,4);
    step(1,0,0, 4'h1,4'h7,64'hDD,64'h20,4'h1,4'h2,      4'h1,4'h7,64'hDD,64'h20,4'h1,4'h2, 0,1, 4,1,4);
    // Exception capture (SHLT) sets frozen.
    step(1,0,0, 4'h2,4'h0,64'hEE,64'h30,4'h6,4'h7,      4'h2,4'h0,64'hEE,64'h30,4'h6,4'h7, 1,1, 4,1,4);
    // While frozen, stall and bubble are ignored and the counters hold.
    step(1,0,0, 4'h1,4'h6,64'hFF,64'h40,4'h8,4'h9,      4'h2,4'h0,64'hEE,64'h30,4'h6,4'h7, 1,1, 4,1,4);
    step(1,0,1, 4'h1,4'h6,64'hFF,64'h40,4'h8,4'h9,      4'h2,4'h0,64'hEE,64'h30,4'h6,4'h7, 1,1, 4,1,4);
    step(1,1,0, 4'h1,4'h6,64'hFF,64'h40,4'h8,4'h9,      4'h2,4'h0,64'hEE,64'h30,4'h6,4'h7, 1,1, 4,1,4);
    step(1,0,1, 4'h1,4'h6,64'hFF,64'h40,4'h8,4'h9,      4'h2,4'h0,64'hEE,64'h30,4'h6,4'h7, 1,1, 4,1,4);
    // Reset overrides frozen.
    step(0,0,0, 4'h1,4'h6,64'hFF,64'h40,4'h8,4'h9,      4'h1,4'h1,64'h0,64'h0,4'hF,4'hF, 0,0, 0,0,0);
    // Ten stall cycles: the 3-bit counter saturates at 7.
    for (int i = 1; i <= 10; i++)
      step(1,1,0, 4'h1,4'h3,64'h99,64'h50,4'hA,4'hB,    4'h1,4'h1,64'h0,64'h0,4'hF,4'hF, 0,0, i,0,(i > 7) ? 7 : i);
    step(1,0,0, 4'h1,4'h3,64'h99,64'h50,4'hA,4'hB,      4'h1,4'h3,64'h99,64'h50,4'hA,4'hB, 0,0, 10,0,7);

    // Drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
